// File: rtl/seq_detect_pkg.sv
// Elaboration-time helpers for the serial pattern detector: length limits,
// KMP next-state computation and pattern border.
package seq_detect_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  function automatic logic get_bit(input logic [31:0] vec, input int idx);
    logic [31:0] tmp;
    tmp = vec >> idx;
    return tmp[0];
  endfunction

  // Pattern bit i in arrival order; pattern MSB arrives first.
  function automatic logic pat_bit(input logic [31:0] pat, input int len, input int i);
    return get_bit(pat, len - 1 - i);
  endfunction

  // Next state from state k on bit b: longest j (capped at len-1) such that the
  // last j bits of (first k pattern bits, b) equal the first j pattern bits.
  // At k = len-1 with a matching bit this yields the overlap border.
  function automatic int kmp_next(input logic [31:0] pat, input int len,
                                  input int k, input logic b);
    logic [31:0] s;
    int          best;
    logic        ok;
    s = '0;
    for (int i = 0; i < k; i++)
      if (pat_bit(pat, len, i)) s = s | (32'd1 << i);
    if (b) s = s | (32'd1 << k);
    best = 0;
    for (int j = 1; j <= k + 1; j++) begin
      if (j <= len - 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (get_bit(s, k + 1 - j + i) != pat_bit(pat, len, i)) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int pat_border(input logic [31:0] pat, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < len; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (pat_bit(pat, len, len - j + i) != pat_bit(pat, len, i)) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_param_cnt.sv
// Saturating match counter; clear has priority over increment.
// One-cycle update latency, no flow control.
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with KMP fallback and match counter.
// Match pulse one cycle after the final bit; bits are consumed only while in_valid is high.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       cnt_clr,
  output logic                       out,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(PAT_LEN)-1:0] progress
);

  localparam int   SW       = $clog2(PAT_LEN);
  localparam int   LAST     = PAT_LEN - 1;
  localparam logic LAST_BIT = PATTERN[0];
  localparam int   BORDER   = pat_border(32'(PATTERN), PAT_LEN);

  if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_len
    $error("seq_detect_param: PAT_LEN out of legal range");
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic          detect;
  logic [SW-1:0] nxt0 [PAT_LEN];
  logic [SW-1:0] nxt1 [PAT_LEN];
  logic [SW-1:0] border_state;

  // Constant transition table, one entry per state and input bit.
  for (genvar k = 0; k < PAT_LEN; k++) begin : g_tab
    localparam int N0 = kmp_next(32'(PATTERN), PAT_LEN, k, 1'b0);
    localparam int N1 = kmp_next(32'(PATTERN), PAT_LEN, k, 1'b1);
    assign nxt0[k] = SW'(N0);
    assign nxt1[k] = SW'(N1);
  end

  assign border_state = SW'(BORDER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= detect;
    end
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      if (detect) begin
        state_nxt = (OVERLAP != 0) ? border_state : '0;
      end else begin
        state_nxt = in ? nxt1[state] : nxt0[state];
      end
    end
  end

  always_comb begin
    detect   = in_valid && (state == SW'(LAST)) && (in == LAST_BIT);
    progress = state;
  end

  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (detect),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule
